// File: rtl/axi_chan_fifo.sv
// rtl/axi_chan_fifo.sv - AXI4 five-channel register FIFO; AXI_CHAN_FIFO_ASSERT_EN adds channel assertions
// The package holds default channel structs so the top elaborates stand-alone.
package axi_chan_fifo_pkg;
   typedef struct packed {
      logic [15:0] addr;
      logic [3:0]  id;
   } aw_chan_t;
   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } w_chan_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;
   typedef struct packed {
      logic [15:0] addr;
      logic [3:0]  id;
   } ar_chan_t;
   typedef struct packed {
      logic [3:0] id;
      logic [7:0] data;
      logic [1:0] resp;
      logic       last;
   } r_chan_t;
   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      ar_chan_t ar;
      logic     ar_valid;
      logic     b_ready;
      logic     r_ready;
   } axi_req_t;
   typedef struct packed {
      logic     aw_ready;
      logic     w_ready;
      logic     ar_ready;
      b_chan_t  b;
      logic     b_valid;
      r_chan_t  r;
      logic     r_valid;
   } axi_resp_t;
endpackage

module axi_chan_fifo_chan #(
   parameter int  Depth       = 4,
   parameter bit  FallThrough = 1'b0,
   parameter type T           = logic
) (
   input  logic clk,
   input  logic rst_n,
   input  T     in_data,
   input  logic in_valid,
   output logic in_ready,
   output T     out_data,
   output logic out_valid,
   input  logic out_ready
);
   localparam int CW = $clog2(Depth + 1);
   localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

   T              mem [Depth];
   logic [PW-1:0] rptr, wptr;
   logic [CW-1:0] count;
   logic          full, empty, push, pop, bypass, store, drain;

   assign full      = (count == CW'(Depth));
   assign empty     = (count == '0);
   assign in_ready  = !full;
   assign out_valid = !empty || (FallThrough && in_valid);
   assign out_data  = (FallThrough && empty) ? in_data : mem[rptr];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   // A fall-through beat consumed in the same cycle never touches storage.
   assign bypass    = FallThrough && empty && out_ready;
   assign store     = push && !bypass;
   assign drain     = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else begin
         if (store) begin
            mem[wptr] <= in_data;
            wptr      <= (wptr == PW'(Depth - 1)) ? '0 : wptr + PW'(1);
         end
         if (drain) rptr <= (rptr == PW'(Depth - 1)) ? '0 : rptr + PW'(1);
         case ({store, drain})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef AXI_CHAN_FIFO_ASSERT_EN
   a_depth: assert property (@(posedge clk) Depth >= 0)
      else $error("%m: negative depth");
   a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
      in_valid && !in_ready |=> in_valid && $stable(in_data))
      else $error("%m: input valid/payload changed before handshake");
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
      else $error("%m: push while full");
   a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid && !out_ready |=> out_valid && $stable(out_data))
      else $error("%m: output valid/payload changed before handshake");
`endif
endmodule

module axi_chan_fifo #(
   parameter int  Depth       = 4,
   parameter bit  FallThrough = 1'b0,
   parameter type aw_chan_t   = axi_chan_fifo_pkg::aw_chan_t,
   parameter type w_chan_t    = axi_chan_fifo_pkg::w_chan_t,
   parameter type b_chan_t    = axi_chan_fifo_pkg::b_chan_t,
   parameter type ar_chan_t   = axi_chan_fifo_pkg::ar_chan_t,
   parameter type r_chan_t    = axi_chan_fifo_pkg::r_chan_t,
   parameter type axi_req_t   = axi_chan_fifo_pkg::axi_req_t,
   parameter type axi_resp_t  = axi_chan_fifo_pkg::axi_resp_t
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      test_i,
   input  axi_req_t  slv_req_i,
   output axi_resp_t slv_resp_o,
   output axi_req_t  mst_req_o,
   input  axi_resp_t mst_resp_i
);
   logic [2:0] unused_sink;
   assign unused_sink = {test_i, clk_i, rst_ni};

   if (Depth == 0) begin : g_bypass
      always_comb begin
         mst_req_o  = slv_req_i;
         slv_resp_o = mst_resp_i;
      end
   end else begin : g_fifo
      aw_chan_t aw_data;
      w_chan_t  w_data;
      ar_chan_t ar_data;
      b_chan_t  b_data;
      r_chan_t  r_data;
      logic aw_valid, w_valid, ar_valid, b_valid, r_valid;
      logic aw_ready, w_ready, ar_ready, b_ready, r_ready;

      axi_chan_fifo_chan #(.Depth(Depth), .FallThrough(FallThrough), .T(aw_chan_t)) i_aw (
         .clk(clk_i), .rst_n(rst_ni),
         .in_data(slv_req_i.aw), .in_valid(slv_req_i.aw_valid), .in_ready(aw_ready),
         .out_data(aw_data), .out_valid(aw_valid), .out_ready(mst_resp_i.aw_ready));
      axi_chan_fifo_chan #(.Depth(Depth), .FallThrough(FallThrough), .T(w_chan_t)) i_w (
         .clk(clk_i), .rst_n(rst_ni),
         .in_data(slv_req_i.w), .in_valid(slv_req_i.w_valid), .in_ready(w_ready),
         .out_data(w_data), .out_valid(w_valid), .out_ready(mst_resp_i.w_ready));
      axi_chan_fifo_chan #(.Depth(Depth), .FallThrough(FallThrough), .T(ar_chan_t)) i_ar (
         .clk(clk_i), .rst_n(rst_ni),
         .in_data(slv_req_i.ar), .in_valid(slv_req_i.ar_valid), .in_ready(ar_ready),
         .out_data(ar_data), .out_valid(ar_valid), .out_ready(mst_resp_i.ar_ready));
      axi_chan_fifo_chan #(.Depth(Depth), .FallThrough(FallThrough), .T(b_chan_t)) i_b (
         .clk(clk_i), .rst_n(rst_ni),
         .in_data(mst_resp_i.b), .in_valid(mst_resp_i.b_valid), .in_ready(b_ready),
         .out_data(b_data), .out_valid(b_valid), .out_ready(slv_req_i.b_ready));
      axi_chan_fifo_chan #(.Depth(Depth), .FallThrough(FallThrough), .T(r_chan_t)) i_r (
         .clk(clk_i), .rst_n(rst_ni),
         .in_data(mst_resp_i.r), .in_valid(mst_resp_i.r_valid), .in_ready(r_ready),
         .out_data(r_data), .out_valid(r_valid), .out_ready(slv_req_i.r_ready));

      always_comb begin
         mst_req_o          = '0;
         mst_req_o.aw       = aw_data;
         mst_req_o.aw_valid = aw_valid;
         mst_req_o.w        = w_data;
         mst_req_o.w_valid  = w_valid;
         mst_req_o.ar       = ar_data;
         mst_req_o.ar_valid = ar_valid;
         mst_req_o.b_ready  = b_ready;
         mst_req_o.r_ready  = r_ready;
         slv_resp_o          = '0;
         slv_resp_o.aw_ready = aw_ready;
         slv_resp_o.w_ready  = w_ready;
         slv_resp_o.ar_ready = ar_ready;
         slv_resp_o.b        = b_data;
         slv_resp_o.b_valid  = b_valid;
         slv_resp_o.r        = r_data;
         slv_resp_o.r_valid  = r_valid;
      end
   end
endmodule

// File: tb/tb_axi_chan_fifo.sv
// tb/tb_axi_chan_fifo.sv - self-checking bench for axi_chan_fifo (Depth 4, fall-through, Depth 0)
module tb_axi_chan_fifo;
   import axi_chan_fifo_pkg::*;

   localparam int AWB = $bits(aw_chan_t);
   localparam int WB  = $bits(w_chan_t);
   localparam int ARB = $bits(ar_chan_t);
   localparam int BB  = $bits(b_chan_t);
   localparam int RB  = $bits(r_chan_t);

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   logic test = 1'b0;

   // Channel-indexed view of the main DUT: 0 AW, 1 W, 2 AR, 3 B, 4 R
   logic [4:0]  in_valid, out_ready, out_valid, in_ready;
   logic [31:0] in_data  [5];
   logic [31:0] out_data [5];

   axi_req_t  slv_req, mst_req;
   axi_resp_t slv_resp, mst_resp;
   axi_req_t  ft_req, ft_mst_req;
   axi_resp_t ft_resp, ft_slv_resp;
   axi_req_t  d0_req, d0_mst_req;
   axi_resp_t d0_resp, d0_slv_resp;

   axi_chan_fifo #(.Depth(4), .FallThrough(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .test_i(test),
      .slv_req_i(slv_req), .slv_resp_o(slv_resp), .mst_req_o(mst_req), .mst_resp_i(mst_resp));
   axi_chan_fifo #(.Depth(4), .FallThrough(1'b1)) dut_ft (
      .clk_i(clk), .rst_ni(rst_n), .test_i(test),
      .slv_req_i(ft_req), .slv_resp_o(ft_slv_resp), .mst_req_o(ft_mst_req), .mst_resp_i(ft_resp));
   axi_chan_fifo #(.Depth(0), .FallThrough(1'b0)) dut_d0 (
      .clk_i(clk), .rst_ni(rst_n), .test_i(test),
      .slv_req_i(d0_req), .slv_resp_o(d0_slv_resp), .mst_req_o(d0_mst_req), .mst_resp_i(d0_resp));

   always_comb begin
      slv_req           = '0;
      mst_resp          = '0;
      slv_req.aw        = aw_chan_t'(in_data[0][AWB-1:0]);
      slv_req.aw_valid  = in_valid[0];
      slv_req.w         = w_chan_t'(in_data[1][WB-1:0]);
      slv_req.w_valid   = in_valid[1];
      slv_req.ar        = ar_chan_t'(in_data[2][ARB-1:0]);
      slv_req.ar_valid  = in_valid[2];
      slv_req.b_ready   = out_ready[3];
      slv_req.r_ready   = out_ready[4];
      mst_resp.aw_ready = out_ready[0];
      mst_resp.w_ready  = out_ready[1];
      mst_resp.ar_ready = out_ready[2];
      mst_resp.b        = b_chan_t'(in_data[3][BB-1:0]);
      mst_resp.b_valid  = in_valid[3];
      mst_resp.r        = r_chan_t'(in_data[4][RB-1:0]);
      mst_resp.r_valid  = in_valid[4];
      for (int c = 0; c < 5; c++) out_data[c] = '0;
      out_data[0][AWB-1:0] = mst_req.aw;
      out_data[1][WB-1:0]  = mst_req.w;
      out_data[2][ARB-1:0] = mst_req.ar;
      out_data[3][BB-1:0]  = slv_resp.b;
      out_data[4][RB-1:0]  = slv_resp.r;
      out_valid = {slv_resp.r_valid, slv_resp.b_valid, mst_req.ar_valid, mst_req.w_valid, mst_req.aw_valid};
      in_ready  = {mst_req.r_ready, mst_req.b_ready, slv_resp.ar_ready, slv_resp.w_ready, slv_resp.aw_ready};
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        rdy;
      logic        exp_ready;
      logic        exp_valid;
      logic [31:0] exp_d;
   } vec_t;
   vec_t tbl [11];

   logic [31:0] q [5][$];
   int          wid [5];
   logic [4:0]  hold;

   initial begin
      // AW fill/stall/drain vectors: push 1..4 with downstream stalled, 5 waits for space
      tbl[0]  = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0};
      tbl[1]  = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 32'd1};
      tbl[2]  = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 32'd1};
      tbl[3]  = '{1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 32'd1};
      tbl[4]  = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd1};
      tbl[5]  = '{1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd1};
      tbl[6]  = '{1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 32'd2};
      tbl[7]  = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd3};
      tbl[8]  = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd4};
      tbl[9]  = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd5};
      tbl[10] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0};
      wid = '{AWB, WB, ARB, BB, RB};

      ft_req = '0; ft_resp = '0; d0_req = '0; d0_resp = '0;
      rst_n = 1'b0;
      in_valid = '1; out_ready = '0;
      for (int c = 0; c < 5; c++) in_data[c] = '0;

      // Reset held two cycles with all input valids high
      for (int k = 0; k < 2; k++) begin
         tick(); #2;
         for (int c = 0; c < 5; c++) begin
            chk($sformatf("rst_out_valid[%0d]", c), out_valid[c], 1'b0);
            chk($sformatf("rst_in_ready[%0d]", c), in_ready[c], 1'b1);
            chk($sformatf("rst_out_data[%0d]", c), out_data[c], 32'd0);
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) in_data[c] = 32'(c + 1);
      tick(); #2;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("first_valid[%0d]", c), out_valid[c], 1'b1);
         chk($sformatf("first_data[%0d]", c), out_data[c], 32'(c + 1));
      end
      in_valid = '0; out_ready = '1;
      tick(); #2;
      for (int c = 0; c < 5; c++) chk($sformatf("drained[%0d]", c), out_valid[c], 1'b0);
      out_ready = '0;
      tick();

      for (int i = 0; i < 11; i++) begin
         in_valid[0]  = tbl[i].v;
         in_data[0]   = tbl[i].d;
         out_ready[0] = tbl[i].rdy;
         #2;
         chk($sformatf("aw_ready[%0d]", i), in_ready[0], tbl[i].exp_ready);
         chk($sformatf("aw_valid[%0d]", i), out_valid[0], tbl[i].exp_valid);
         if (tbl[i].exp_valid) chk($sformatf("aw_id[%0d]", i), out_data[0], tbl[i].exp_d);
         tick();
      end

      // R streaming: 8 beats, last on beat 8, one cycle latency, no bubbles
      out_ready[4] = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         in_valid[4] = (k < 8);
         in_data[4]  = (k < 8) ? ((32'(k) << 3) | 32'(k == 7)) : 32'd0;
         #2;
         chk($sformatf("r_ready[%0d]", k), in_ready[4], 1'b1);
         chk($sformatf("r_valid[%0d]", k), out_valid[4], k > 0);
         if (k > 0) chk($sformatf("r_beat[%0d]", k), out_data[4], (32'(k - 1) << 3) | 32'(k == 8));
         tick();
      end
      in_valid[4] = 1'b0;
      #2; chk("r_idle", out_valid[4], 1'b0);
      out_ready[4] = 1'b0;

      // B backpressure: two beats held stable while ready toggles
      in_valid[3] = 1'b1; in_data[3] = 32'h05; tick();
      in_data[3] = 32'h0A; tick();
      in_valid[3] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         out_ready[3] = k[0];
         #2;
         chk($sformatf("b_valid[%0d]", k), out_valid[3], k < 4);
         if (k < 4) chk($sformatf("b_data[%0d]", k), out_data[3], (k < 2) ? 32'h05 : 32'h0A);
         tick();
      end
      out_ready[3] = 1'b0;

      // AR: three buffered beats discarded by a one-cycle reset
      in_valid[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data[2] = 32'(k + 8);
         tick();
      end
      in_valid[2] = 1'b0;
      #2; chk("ar_buffered", out_valid[2], 1'b1);
      rst_n = 1'b0;
      tick(); #2;
      chk("ar_valid_after_rst", out_valid[2], 1'b0);
      chk("ar_ready_after_rst", in_ready[2], 1'b1);
      chk("ar_data_after_rst", out_data[2], 32'd0);
      rst_n = 1'b1; out_ready[2] = 1'b1;
      tick(); #2;
      chk("ar_gone", out_valid[2], 1'b0);
      out_ready[2] = 1'b0;
      tick();

      // Randomized traffic on all channels against queue model
      hold = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < 5; c++) begin
            if (!hold[c]) begin
               in_valid[c] = 1'($urandom_range(0, 1));
               in_data[c]  = $urandom & ((32'h1 << wid[c]) - 32'h1);
            end
            out_ready[c] = cyc[6] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         end
         #2;
         for (int c = 0; c < 5; c++) begin
            logic ev, er, acc, pop;
            ev = (q[c].size() != 0);
            er = (q[c].size() < 4);
            chk($sformatf("rnd_valid c%0d cyc%0d", c, cyc), out_valid[c], ev);
            chk($sformatf("rnd_ready c%0d cyc%0d", c, cyc), in_ready[c], er);
            if (ev) chk($sformatf("rnd_data c%0d cyc%0d", c, cyc), out_data[c], q[c][0]);
            acc = in_valid[c] && er;
            pop = ev && out_ready[c];
            if (pop) void'(q[c].pop_front());
            if (acc) q[c].push_back(in_data[c]);
            hold[c] = in_valid[c] && !acc;
         end
         tick();
      end

      // Fall-through W: bypass when drained same cycle, store when stalled
      ft_req.w = '{data: 8'hA5, last: 1'b1}; ft_req.w_valid = 1'b1; ft_resp.w_ready = 1'b1;
      #2;
      chk("ft_w_valid", ft_mst_req.w_valid, 1'b1);
      chk("ft_w_data", ft_mst_req.w.data, 8'hA5);
      chk("ft_w_ready", ft_slv_resp.w_ready, 1'b1);
      tick();
      ft_req.w_valid = 1'b0;
      #2; chk("ft_w_empty", ft_mst_req.w_valid, 1'b0);
      ft_req.w = '{data: 8'h3C, last: 1'b0}; ft_req.w_valid = 1'b1; ft_resp.w_ready = 1'b0;
      #2;
      chk("ft_stall_valid", ft_mst_req.w_valid, 1'b1);
      chk("ft_stall_data", ft_mst_req.w.data, 8'h3C);
      tick();
      ft_req.w_valid = 1'b0; ft_resp.w_ready = 1'b1;
      #2;
      chk("ft_stored_valid", ft_mst_req.w_valid, 1'b1);
      chk("ft_stored_data", ft_mst_req.w.data, 8'h3C);
      tick(); #2;
      chk("ft_stored_gone", ft_mst_req.w_valid, 1'b0);

      // Depth 0: combinational pass-through
      for (int k = 0; k < 6; k++) begin
         logic [63:0] r;
         r = {$urandom, $urandom};
         d0_req  = axi_req_t'(r[$bits(axi_req_t)-1:0]);
         d0_resp = axi_resp_t'(r[$bits(axi_resp_t)-1:0] ^ 26'h2AA_AAAA);
         #2;
         chk($sformatf("d0_req[%0d]", k), 64'(d0_mst_req), 64'(d0_req));
         chk($sformatf("d0_resp[%0d]", k), 64'(d0_slv_resp), 64'(d0_resp));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
